net_hold_resolver: RTL and testbench
====================================

# net_hold_resolver

- Clocked, parametrised model of a multi-driven 4-state net.
- Resolves NDRV drivers per bit using wire, wor/trior or wand/triand rules.
- Registers the result and, when no driver is enabled, holds the last value like a trireg until a programmable decay time expires, after which the net reads X.
- Sits between the generated driver stimulus and the net checkers in the multi-driven-net test flow, and supplies conflict and decay status to the checkers.

## Interface

Parameters:
- WIDTH, 8: bits per net.
- NDRV, 4: number of drivers (≥1).
- MODE, 0: resolution rule. 0 = wire/tri, 1 = wor/trior, 2 = wand/triand. Any other value is illegal and must be flagged by an elaboration-time assertion.
- DECAY, 15: hold time in cycles. 0 means hold forever (no decay).

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- drv_en, input, NDRV: per-driver enable. A disabled driver is Z on all bits.
- drv_val, input, NDRV*WIDTH: driver value plane. Driver i occupies bits [i*WIDTH +: WIDTH].
- drv_x, input, NDRV*WIDTH: driver unknown plane. A set bit means that driver bit is X and its value bit is ignored.
- cnt_clr, input, 1: synchronous clear of conflict_cnt.
- bus_val, output, WIDTH: resolved value plane. Meaningful only where bus_x is 0.
- bus_x, output, WIDTH: resolved unknown plane.
- state, output, 2: 0 = DRIVEN, 1 = HOLD, 2 = DECAYED.
- conflict, output, 1: registered flag. Set if the last resolved cycle had any bit X due to driver disagreement (MODE 0 only).
- conflict_cnt, output, 16: saturating count of conflict cycles.
- decay_evt, output, 1: one-cycle pulse on the HOLD→DECAYED transition.

## Operation

Per-bit resolution over enabled drivers only (combinational, then registered):
- MODE 0: all enabled drivers known and equal → that value. Any enabled X → X. Known disagreement → X plus conflict.
- MODE 1: any enabled known 1 → 1; else any enabled X → X; else 0.
- MODE 2: any enabled known 0 → 0; else any enabled X → X; else 1.
- In MODE 1 and MODE 2, conflict is always 0.

FSM, evaluated each rising edge:
- **DRIVEN** (|drv_en = 1 at the edge):
  - bus_val/bus_x ← resolved value.
  - Hold counter ← DECAY.
  - This applies from any state, so drivers re-enabling during HOLD or DECAYED return to DRIVEN in one edge.
- **First edge with drv_en = 0 from DRIVEN** → HOLD:
  - Outputs unchanged.
  - Counter ← DECAY−1, or no decrement if DECAY = 0.
- **HOLD with drv_en = 0**:
  - If DECAY ≠ 0 and counter = 0: → DECAYED, bus_x ← all ones, bus_val ← 0, decay_evt = 1 for that cycle.
  - Otherwise counter decrements; outputs unchanged.
  - DECAY = 0: stay in HOLD indefinitely.
- **DECAYED with drv_en = 0**: remain; outputs stay all-X.

Conflict counter:
- Increments on each edge where the resolved cycle has conflict.
- Saturates at 16'hFFFF.
- cnt_clr at the same edge wins: result is 0, not 1.
- conflict itself is not affected by cnt_clr.

Reset values (asserted asynchronously, immediately):
- state = DECAYED, bus_val = 0, bus_x = all ones (an uncharged trireg reads X).
- conflict = 0, conflict_cnt = 0, decay_evt = 0, hold counter = 0.
- Reset mid-HOLD discards the held value.

Hold counter width is clog2(DECAY+1), minimum 1.

## Timing

- Latency: drivers sampled at edge n appear on bus_val/bus_x/conflict after edge n. Latency is 1 cycle; there is no combinational path from inputs to outputs.
- Hold duration: the held value remains visible for exactly DECAY cycles after the last driven edge. decay_evt is high in the cycle following edge DECAY+1 with no drivers.
- Re-enable on the same edge the counter would expire: DRIVEN wins, and no decay_evt is produced.
- A glitch-free single-cycle drv_en = 0 produces HOLD for one cycle with the value unchanged.
- Reset release: the first edge with rst_n high performs normal evaluation.

## Test plan

1. MODE 0, WIDTH 8, NDRV 4, DECAY 3. Drivers 0 and 1 enabled with val 8'hA5, x 0 → next cycle bus_val A5, bus_x 00, state DRIVEN, conflict 0.
2. MODE 0. Driver 0 = 8'hF0, driver 1 = 8'hFF, both enabled, for 2 cycles → bus_x 8'h0F, bus_val[7:4] = F, conflict 1, conflict_cnt 2. Then cnt_clr together with another conflict cycle → conflict_cnt 0.
3. DECAY 3: drive 8'h3C, then drop all enables → HOLD with 3C for 3 cycles. On the 4th edge: state DECAYED, bus_x FF, decay_evt high for exactly one cycle. Variant: re-enable on the 4th edge → DRIVEN, no decay_evt.
4. MODE 1 with drivers 8'h01, 8'h80, and one driver at x 8'hFF → bus_val 81, bus_x 7E. MODE 2 with drivers 8'hFE and 8'h7F → bus_val 7E, bus_x 00.
5. DECAY 0: drive 8'h55, disable for 1000 cycles → state stays HOLD, value 55, no decay_evt.
6. Assert rst_n low mid-HOLD, asynchronously between edges → outputs immediately DECAYED/all-X, counters 0. Force 65536 conflict cycles → conflict_cnt sticks at FFFF.

Source files
------------

// File: rtl/net_hold_resolver_if.sv
// Driver/result bundle for net_hold_resolver: driver planes in, resolved net and status out.
interface net_hold_resolver_if #(
    parameter int WIDTH = 8,
    parameter int NDRV  = 4
);
    logic [NDRV-1:0]       drv_en;
    logic [NDRV*WIDTH-1:0] drv_val;
    logic [NDRV*WIDTH-1:0] drv_x;
    logic                  cnt_clr;
    logic [WIDTH-1:0]      bus_val;
    logic [WIDTH-1:0]      bus_x;
    logic [1:0]            state;
    logic                  conflict;
    logic [15:0]           conflict_cnt;
    logic                  decay_evt;

    modport master (
        output drv_en, drv_val, drv_x, cnt_clr,
        input  bus_val, bus_x, state, conflict, conflict_cnt, decay_evt
    );
    modport slave (
        input  drv_en, drv_val, drv_x, cnt_clr,
        output bus_val, bus_x, state, conflict, conflict_cnt, decay_evt
    );
endinterface

// File: rtl/net_hold_resolver.sv
// Registered multi-driver 4-state net: wire/wor/wand resolution, trireg-style hold
// with programmable decay to X, and conflict status for the net checkers.
module net_hold_resolver #(
    parameter int WIDTH = 8,
    parameter int NDRV  = 4,
    parameter int MODE  = 0,
    parameter int DECAY = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    net_hold_resolver_if.slave nif
);
    localparam int CW = (DECAY < 1) ? 1 : $clog2(DECAY + 1);

    typedef enum logic [1:0] {DRIVEN = 2'd0, HOLD = 2'd1, DECAYED = 2'd2} st_e;

    if (MODE < 0 || MODE > 2) begin : g_bad_mode
        $error("net_hold_resolver: MODE must be 0 (wire), 1 (wor) or 2 (wand)");
    end
    if (NDRV < 1) begin : g_bad_ndrv
        $error("net_hold_resolver: NDRV must be at least 1");
    end

    logic [WIDTH-1:0] res_val, res_x, res_cf;

    // Per-bit reduction over enabled drivers: known-1, known-0 and unknown votes.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [NDRV-1:0] k1, k0, kx;
        logic            any1, any0, anyx;
        for (genvar d = 0; d < NDRV; d++) begin : g_drv
            assign k1[d] = nif.drv_en[d] & ~nif.drv_x[d*WIDTH+b] &  nif.drv_val[d*WIDTH+b];
            assign k0[d] = nif.drv_en[d] & ~nif.drv_x[d*WIDTH+b] & ~nif.drv_val[d*WIDTH+b];
            assign kx[d] = nif.drv_en[d] &  nif.drv_x[d*WIDTH+b];
        end
        assign any1 = |k1;
        assign any0 = |k0;
        assign anyx = |kx;
        if (MODE == 1) begin : g_wor
            assign res_val[b] = any1;
            assign res_x[b]   = ~any1 & anyx;
            assign res_cf[b]  = 1'b0;
        end else if (MODE == 2) begin : g_wand
            assign res_val[b] = ~any0 & ~anyx;
            assign res_x[b]   = ~any0 & anyx;
            assign res_cf[b]  = 1'b0;
        end else begin : g_wire
            assign res_cf[b]  = any1 & any0;
            assign res_x[b]   = anyx | res_cf[b];
            assign res_val[b] = any1 & ~res_x[b];
        end
    end

    st_e              st_q, st_n;
    logic [WIDTH-1:0] val_q, val_n, x_q, x_n;
    logic [CW-1:0]    hc_q, hc_n;
    logic             cf_q, cf_n, evt_q, evt_n;
    logic [15:0]      cc_q, cc_n;
    logic             driven;

    assign driven = |nif.drv_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= DECAYED;
            val_q <= '0;
            x_q   <= '1;
            hc_q  <= '0;
            cf_q  <= 1'b0;
            cc_q  <= '0;
            evt_q <= 1'b0;
        end else begin
            st_q  <= st_n;
            val_q <= val_n;
            x_q   <= x_n;
            hc_q  <= hc_n;
            cf_q  <= cf_n;
            cc_q  <= cc_n;
            evt_q <= evt_n;
        end
    end

    always_comb begin
        st_n  = st_q;
        val_n = val_q;
        x_n   = x_q;
        hc_n  = hc_q;
        evt_n = 1'b0;
        cf_n  = driven & (|res_cf);
        if (nif.cnt_clr)
            cc_n = '0;
        else if (cf_n && cc_q != 16'hFFFF)
            cc_n = cc_q + 16'd1;
        else
            cc_n = cc_q;

        if (driven) begin
            st_n  = DRIVEN;
            val_n = res_val;
            x_n   = res_x;
            hc_n  = CW'(DECAY);
        end else begin
            case (st_q)
                // hc_q holds DECAY here, so a single decrement lands on DECAY-1.
                DRIVEN: begin
                    st_n = HOLD;
                    if (DECAY != 0) hc_n = hc_q - 1'b1;
                end
                HOLD: begin
                    if (DECAY != 0) begin
                        if (hc_q == '0) begin
                            st_n  = DECAYED;
                            val_n = '0;
                            x_n   = '1;
                            evt_n = 1'b1;
                        end else begin
                            hc_n = hc_q - 1'b1;
                        end
                    end
                end
                DECAYED: st_n = DECAYED;
                default: st_n = DECAYED;
            endcase
        end
    end

    assign nif.bus_val      = val_q;
    assign nif.bus_x        = x_q;
    assign nif.state        = st_q;
    assign nif.conflict     = cf_q;
    assign nif.conflict_cnt = cc_q;
    assign nif.decay_evt    = evt_q;
endmodule

// File: tb/tb_net_hold_resolver.sv
// Scoreboard bench: four net_hold_resolver instances (wire/wor/wand at DECAY 3, wire at DECAY 0)
// share one driver stimulus; expectations are queued per cycle and checked on the falling edge.
module tb_net_hold_resolver;
    localparam int F_VAL = 0, F_X = 1, F_ST = 2, F_CONF = 3, F_CNT = 4, F_EVT = 5;

    typedef struct {
        int          at_cyc;
        int          dut;
        int          fld;
        logic [15:0] ev;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  en = '0;
    logic [31:0] val = '0, xp = '0;
    logic        clr = 1'b0;
    int          cyc = 0;
    int          nchk = 0, nbad = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    net_hold_resolver_if #(.WIDTH(8), .NDRV(4)) if0 ();
    net_hold_resolver_if #(.WIDTH(8), .NDRV(4)) if1 ();
    net_hold_resolver_if #(.WIDTH(8), .NDRV(4)) if2 ();
    net_hold_resolver_if #(.WIDTH(8), .NDRV(4)) if3 ();

    assign if0.drv_en = en; assign if0.drv_val = val; assign if0.drv_x = xp; assign if0.cnt_clr = clr;
    assign if1.drv_en = en; assign if1.drv_val = val; assign if1.drv_x = xp; assign if1.cnt_clr = clr;
    assign if2.drv_en = en; assign if2.drv_val = val; assign if2.drv_x = xp; assign if2.cnt_clr = clr;
    assign if3.drv_en = en; assign if3.drv_val = val; assign if3.drv_x = xp; assign if3.cnt_clr = clr;

    net_hold_resolver #(.WIDTH(8), .NDRV(4), .MODE(0), .DECAY(3)) u0 (.clk(clk), .rst_n(rst_n), .nif(if0));
    net_hold_resolver #(.WIDTH(8), .NDRV(4), .MODE(1), .DECAY(3)) u1 (.clk(clk), .rst_n(rst_n), .nif(if1));
    net_hold_resolver #(.WIDTH(8), .NDRV(4), .MODE(2), .DECAY(3)) u2 (.clk(clk), .rst_n(rst_n), .nif(if2));
    net_hold_resolver #(.WIDTH(8), .NDRV(4), .MODE(0), .DECAY(0)) u3 (.clk(clk), .rst_n(rst_n), .nif(if3));

    logic [7:0]  bv [4], bx [4];
    logic [1:0]  st [4];
    logic        cf [4], ev [4];
    logic [15:0] cc [4];
    assign bv[0] = if0.bus_val; assign bx[0] = if0.bus_x; assign st[0] = if0.state;
    assign bv[1] = if1.bus_val; assign bx[1] = if1.bus_x; assign st[1] = if1.state;
    assign bv[2] = if2.bus_val; assign bx[2] = if2.bus_x; assign st[2] = if2.state;
    assign bv[3] = if3.bus_val; assign bx[3] = if3.bus_x; assign st[3] = if3.state;
    assign cf[0] = if0.conflict; assign cc[0] = if0.conflict_cnt; assign ev[0] = if0.decay_evt;
    assign cf[1] = if1.conflict; assign cc[1] = if1.conflict_cnt; assign ev[1] = if1.decay_evt;
    assign cf[2] = if2.conflict; assign cc[2] = if2.conflict_cnt; assign ev[2] = if2.decay_evt;
    assign cf[3] = if3.conflict; assign cc[3] = if3.conflict_cnt; assign ev[3] = if3.decay_evt;

    function automatic logic [15:0] act(input int d, input int f);
        case (f)
            F_VAL:   return {8'h00, bv[d]};
            F_X:     return {8'h00, bx[d]};
            F_ST:    return {14'h0, st[d]};
            F_CONF:  return {15'h0, cf[d]};
            F_CNT:   return cc[d];
            default: return {15'h0, ev[d]};
        endcase
    endfunction

    // Monitor: every expectation tagged with the current edge count is compared here.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [15:0] a;
        while (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
            e = sb.pop_front();
            a = act(e.dut, e.fld);
            nchk++;
            if (e.at_cyc < cyc) begin
                nbad++;
                $display("FAIL %s dut%0d: expectation for cycle %0d not checked in time", e.nm, e.dut, e.at_cyc);
            end else if (a !== e.ev) begin
                nbad++;
                $display("FAIL %s dut%0d cyc %0d: got %h want %h", e.nm, e.dut, cyc, a, e.ev);
            end
        end
    end

    task automatic push(input int ofs, input int d, input int f, input int v, input string nm);
        exp_t e;
        e.at_cyc = cyc + ofs;
        e.dut    = d;
        e.fld    = f;
        e.ev     = 16'(v);
        e.nm     = nm;
        sb.push_back(e);
    endtask

    task automatic ex(input int d, input int f, input int v, input string nm);
        push(1, d, f, v, nm);
    endtask

    task automatic drive(input logic [3:0] e, input logic [31:0] v, input logic [31:0] x);
        en  = e;
        val = v;
        xp  = x;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        ex(0, F_ST, 2, "rst_state"); ex(0, F_X, 8'hFF, "rst_x"); ex(0, F_VAL, 0, "rst_val");
        ex(0, F_CNT, 0, "rst_cnt"); ex(0, F_CONF, 0, "rst_conf"); ex(0, F_EVT, 0, "rst_evt");
        step();
        rst_n = 1'b1;

        // agreeing drivers
        drive(4'b0011, 32'h0000_A5A5, 32'h0);
        ex(0, F_VAL, 8'hA5, "agree_val"); ex(0, F_X, 0, "agree_x");
        ex(0, F_ST, 0, "agree_state"); ex(0, F_CONF, 0, "agree_conf"); ex(0, F_CNT, 0, "agree_cnt");
        ex(3, F_VAL, 8'hA5, "agree_val_d0");
        step();

        // disagreement on the low nibble, then clear racing a conflict
        drive(4'b0011, 32'h0000_FFF0, 32'h0);
        ex(0, F_VAL, 8'hF0, "cf_val"); ex(0, F_X, 8'h0F, "cf_x");
        ex(0, F_CONF, 1, "cf_flag"); ex(0, F_CNT, 1, "cf_cnt1");
        ex(1, F_VAL, 8'hFF, "wor_agree_val"); ex(1, F_CONF, 0, "wor_no_conf");
        ex(2, F_VAL, 8'hF0, "wand_agree_val"); ex(2, F_X, 0, "wand_agree_x");
        step();
        ex(0, F_CNT, 2, "cf_cnt2"); ex(0, F_CONF, 1, "cf_flag2");
        step();
        clr = 1'b1;
        ex(0, F_CNT, 0, "clr_wins"); ex(0, F_CONF, 1, "clr_keeps_flag");
        step();
        clr = 1'b0;

        // hold then decay
        drive(4'b0011, 32'h0000_3C3C, 32'h0);
        ex(0, F_VAL, 8'h3C, "pre_hold_val"); ex(0, F_ST, 0, "pre_hold_state");
        step();
        drive(4'b0000, 32'h0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            ex(0, F_ST, 1, "hold_state"); ex(0, F_VAL, 8'h3C, "hold_val");
            ex(0, F_X, 0, "hold_x"); ex(0, F_EVT, 0, "hold_noevt");
            step();
        end
        ex(0, F_ST, 2, "decay_state"); ex(0, F_X, 8'hFF, "decay_x");
        ex(0, F_VAL, 0, "decay_val"); ex(0, F_EVT, 1, "decay_evt");
        ex(3, F_ST, 1, "nodecay_state"); ex(3, F_VAL, 8'h3C, "nodecay_val");
        step();
        ex(0, F_EVT, 0, "decay_evt_once"); ex(0, F_ST, 2, "decay_stays");
        step();

        // re-enable on the expiry edge
        drive(4'b0011, 32'h0000_3C3C, 32'h0);
        ex(0, F_ST, 0, "redrive_state");
        step();
        drive(4'b0000, 32'h0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            ex(0, F_ST, 1, "hold2_state");
            step();
        end
        drive(4'b0011, 32'h0000_5A5A, 32'h0);
        ex(0, F_ST, 0, "reen_state"); ex(0, F_VAL, 8'h5A, "reen_val"); ex(0, F_EVT, 0, "reen_noevt");
        step();
        ex(0, F_EVT, 0, "reen_noevt2");
        step();

        // single-cycle glitch
        drive(4'b0000, 32'h0, 32'h0);
        ex(0, F_ST, 1, "glitch_hold"); ex(0, F_VAL, 8'h5A, "glitch_val");
        step();
        drive(4'b0011, 32'h0000_6666, 32'h0);
        ex(0, F_ST, 0, "glitch_back"); ex(0, F_VAL, 8'h66, "glitch_newval");
        step();

        // wor / wand resolution
        drive(4'b0111, 32'h0000_8001, 32'h00FF_0000);
        ex(1, F_VAL, 8'h81, "wor_val"); ex(1, F_X, 8'h7E, "wor_x"); ex(1, F_CONF, 0, "wor_conf");
        ex(2, F_VAL, 0, "wand_zero_val"); ex(2, F_X, 0, "wand_zero_x");
        ex(0, F_X, 8'hFF, "wire_allx"); ex(0, F_VAL, 0, "wire_allx_val");
        step();
        drive(4'b0011, 32'h0000_7FFE, 32'h0);
        ex(2, F_VAL, 8'h7E, "wand_val"); ex(2, F_X, 0, "wand_x"); ex(2, F_CONF, 0, "wand_conf");
        ex(1, F_VAL, 8'hFF, "wor_val2"); ex(1, F_X, 0, "wor_x2");
        ex(0, F_VAL, 8'h7E, "wire_edges_val"); ex(0, F_X, 8'h81, "wire_edges_x"); ex(0, F_CONF, 1, "wire_edges_conf");
        step();

        // DECAY 0 holds indefinitely
        drive(4'b0001, 32'h0000_0055, 32'h0);
        ex(3, F_VAL, 8'h55, "d0_val"); ex(3, F_ST, 0, "d0_driven");
        step();
        drive(4'b0000, 32'h0, 32'h0);
        for (int i = 0; i < 1000; i++) begin
            ex(3, F_EVT, 0, "d0_noevt");
            if (i == 999) begin
                ex(3, F_ST, 1, "d0_still_hold"); ex(3, F_VAL, 8'h55, "d0_still_val"); ex(3, F_X, 0, "d0_still_x");
            end
            step();
        end

        // asynchronous reset in the middle of HOLD
        drive(4'b0011, 32'h0000_ABAA, 32'h0);
        ex(0, F_ST, 0, "pre_rst_state"); ex(0, F_CONF, 1, "pre_rst_conf");
        step();
        drive(4'b0000, 32'h0, 32'h0);
        ex(0, F_ST, 1, "pre_rst_hold"); ex(0, F_VAL, 8'hAA, "pre_rst_val"); ex(0, F_X, 8'h01, "pre_rst_x");
        step();
        step();
        #1;
        rst_n = 1'b0;
        push(0, 0, F_ST, 2, "arst_state"); push(0, 0, F_X, 8'hFF, "arst_x"); push(0, 0, F_VAL, 0, "arst_val");
        push(0, 0, F_CNT, 0, "arst_cnt"); push(0, 0, F_CONF, 0, "arst_conf"); push(0, 3, F_ST, 2, "arst_state_d0");
        step();
        rst_n = 1'b1;
        ex(0, F_ST, 2, "post_rst_state"); ex(0, F_X, 8'hFF, "post_rst_x");
        step();

        // counter saturation
        drive(4'b0011, 32'h0000_FF00, 32'h0);
        for (int i = 1; i <= 65540; i++) begin
            if (i == 65534) ex(0, F_CNT, 16'hFFFE, "sat_fffe");
            if (i == 65535) ex(0, F_CNT, 16'hFFFF, "sat_ffff");
            if (i == 65540) ex(0, F_CNT, 16'hFFFF, "sat_stuck");
            step();
        end
        clr = 1'b1;
        ex(0, F_CNT, 0, "sat_clr");
        step();
        clr = 1'b0;

        step();
        step();
        if (sb.size() != 0) begin
            nbad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
        $finish;
    end
endmodule
